fir_out_decimator: RTL and testbench

Output stage placed directly downstream of the FIR filters (direct-form, broadcast, reduced-complexity or L2/L3 parallel). It takes the filter's Q1.15 `data_out` stream, qualified by `en`, and decimates it by 2^DECIM_LOG2. Decimated samples are buffered in a small first-word-fall-through FIFO and leave through a valid/ready handshake, so a slow consumer (capture logic, serializer) can stall without stalling the filter.

---
 rtl/fir_out_pkg.sv | 32 +++
 rtl/fir_out_decimator_if.sv | 41 ++++
 rtl/sync_fifo_fwft.sv | 71 +++++++
 rtl/fir_out_decimator.sv | 100 ++++++++++
 tb/tb_fir_out_decimator.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_out_pkg.sv
// Shared types, defaults and helpers for the FIR output decimator.
// Q1.15 limits and the round/saturate used by the averaging path.
package fir_out_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int DECIM_LOG2_DEF = 1;
  localparam int FIFO_LOG2_DEF  = 2;

  localparam logic [15:0] Q15_MAX = 16'h7FFF;
  localparam logic [15:0] Q15_MIN = 16'h8000;

  // Round-half-up divide by 2^sh, then clamp into Q1.15.
  function automatic logic [15:0] q15_avg(
    input logic signed [31:0] sum,
    input int unsigned        sh
  );
    logic signed [31:0] r;
    if (sh == 0) begin
      r = sum;
    end else begin
      r = (sum + (32'sd1 <<< (sh - 1))) >>> sh;
    end
    if (r > 32'sd32767) begin
      return Q15_MAX;
    end
    if (r < -32'sd32768) begin
      return Q15_MIN;
    end
    return r[15:0];
  endfunction

endpackage

// File: rtl/fir_out_decimator_if.sv
// Sample-in / decimated-out handshake bundle.
// master drives samples and ready, slave is the decimator.
interface fir_out_decimator_if
  import fir_out_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FIFO_LOG2 = FIFO_LOG2_DEF
);

  logic              en;
  logic [DATA_W-1:0] data_in;
  logic              phase_sync;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic [FIFO_LOG2:0] fill;
  logic              overflow;

  modport master (
    output en,
    output data_in,
    output phase_sync,
    output out_ready,
    input  data_out,
    input  out_valid,
    input  fill,
    input  overflow
  );

  modport slave (
    input  en,
    input  data_in,
    input  phase_sync,
    input  out_ready,
    output data_out,
    output out_valid,
    output fill,
    output overflow
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO, power-of-two depth.
// A push into a full FIFO lands only if a pop happens on the same edge.
module sync_fifo_fwft
  import fir_out_pkg::*;
#(
  parameter int W  = DATA_W_DEF,
  parameter int AW = FIFO_LOG2_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [AW:0]  fill_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int D = 1 << AW;

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(D));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_q];
  assign fill_o  = cnt_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fir_out_decimator.sv
// Decimate-by-2^DECIM_LOG2 output stage with FWFT buffering.
// FIR_DECIM_AVG_EN selects integrate-and-dump instead of pick.
module fir_out_decimator
  import fir_out_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DECIM_LOG2 = DECIM_LOG2_DEF,
  parameter int FIFO_LOG2  = FIFO_LOG2_DEF
) (
  input logic                clk,
  input logic                reset,
  fir_out_decimator_if.slave io
);

  localparam int M  = 1 << DECIM_LOG2;
  localparam int PW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [PW-1:0] LAST = PW'(M - 1);

  logic [PW-1:0]      phase_q, phase_d, cur_ph;
  logic               last, push, pop;
  logic               full, empty;
  logic               ovf_q, ovf_d;
  logic [DATA_W-1:0]  push_data, head;
  logic [FIFO_LOG2:0] fill;

  // phase_sync makes the sample on this edge phase 0.
  assign cur_ph = io.phase_sync ? '0 : phase_q;
  assign last   = (cur_ph == LAST);
  assign push   = io.en & last;
  assign pop    = io.out_ready & ~empty;

  // Phase counter next-state.
  always_comb begin
    phase_d = cur_ph;
    if (io.en) phase_d = last ? '0 : cur_ph + PW'(1);
  end

  // Phase counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase_q <= '0;
    else        phase_q <= phase_d;
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int AW = DATA_W + DECIM_LOG2;

  logic signed [AW-1:0] acc_q, acc_d, acc_b, sum;

  assign acc_b = io.phase_sync ? '0 : acc_q;
  assign sum   = acc_b + AW'($signed(io.data_in));
  assign push_data =
    DATA_W'(q15_avg(32'(sum), DECIM_LOG2));

  // Accumulate the group, dump on its last sample.
  always_comb begin
    acc_d = acc_b;
    if (io.en) acc_d = last ? '0 : sum;
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`else
  assign push_data = io.data_in;
`endif

  // A push into a full FIFO with no pop is lost.
  always_comb begin
    ovf_d = ovf_q | (push & full & ~pop);
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  sync_fifo_fwft #(
    .W  (DATA_W),
    .AW (FIFO_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .head_o  (head),
    .fill_o  (fill),
    .full_o  (full),
    .empty_o (empty)
  );

  assign io.data_out  = head;
  assign io.out_valid = ~empty;
  assign io.fill      = fill;
  assign io.overflow  = ovf_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Bench for fir_out_decimator at M=1, 2 and 4, FIFO depth 4.
// Group-list reference model; averaging checks need FIR_DECIM_AVG_EN.
module tb_fir_out_decimator;

  logic clk;
  logic reset;

  int nchk;
  int nfail;

  // Reference model: FIFO contents, open group, sticky overflow.
  int mq[$];
  int grp[$];
  bit movf;

  logic [20:0] obs;
  logic [20:0] exp_v;

  fir_out_decimator_if #(.DATA_W(16), .FIFO_LOG2(2)) if1 ();
  fir_out_decimator_if #(.DATA_W(16), .FIFO_LOG2(2)) if2 ();
  fir_out_decimator_if #(.DATA_W(16), .FIFO_LOG2(2)) if4 ();

  fir_out_decimator #(
    .DATA_W(16), .DECIM_LOG2(0), .FIFO_LOG2(2)
  ) dut1 (.clk(clk), .reset(reset), .io(if1.slave));

  fir_out_decimator #(
    .DATA_W(16), .DECIM_LOG2(1), .FIFO_LOG2(2)
  ) dut2 (.clk(clk), .reset(reset), .io(if2.slave));

  fir_out_decimator #(
    .DATA_W(16), .DECIM_LOG2(2), .FIFO_LOG2(2)
  ) dut4 (.clk(clk), .reset(reset), .io(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lg2(input int m);
    return (m == 1) ? 0 : (m == 2) ? 1 : 2;
  endfunction

  // Value a completed group produces.
  function automatic int group_val(input int m);
    int s;
`ifdef FIR_DECIM_AVG_EN
    s = 0;
    foreach (grp[i]) s += grp[i];
    if (m > 1) s = (s + m / 2) >>> lg2(m);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`else
    s = grp[m-1];
`endif
    return s;
  endfunction

  task automatic idle_all();
    if1.en = 0; if1.data_in = 0; if1.phase_sync = 0; if1.out_ready = 0;
    if2.en = 0; if2.data_in = 0; if2.phase_sync = 0; if2.out_ready = 0;
    if4.en = 0; if4.data_in = 0; if4.phase_sync = 0; if4.out_ready = 0;
  endtask

  task automatic model_clear();
    mq.delete();
    grp.delete();
    movf = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic sample(input int m);
    case (m)
      1: obs = {if1.out_valid, if1.fill, if1.overflow, if1.data_out};
      2: obs = {if2.out_valid, if2.fill, if2.overflow, if2.data_out};
      default:
         obs = {if4.out_valid, if4.fill, if4.overflow, if4.data_out};
    endcase
  endtask

  // One clock: drive, advance the model, sample after the edge.
  task automatic step(input int m, input bit e, input logic [15:0] d,
                      input bit s, input bit r);
    bit popped, pushv, drop;
    int v;
    @(negedge clk);
    case (m)
      1: begin
        if1.en = e; if1.data_in = d; if1.phase_sync = s; if1.out_ready = r;
      end
      2: begin
        if2.en = e; if2.data_in = d; if2.phase_sync = s; if2.out_ready = r;
      end
      default: begin
        if4.en = e; if4.data_in = d; if4.phase_sync = s; if4.out_ready = r;
      end
    endcase
    popped = (mq.size() > 0) && r;
    pushv = 0;
    v = 0;
    if (s) grp.delete();
    if (e) begin
      grp.push_back(int'($signed(d)));
      if (grp.size() == m) begin
        pushv = 1;
        v = group_val(m);
        grp.delete();
      end
    end
    drop = pushv && (mq.size() == 4) && !popped;
    if (drop) movf = 1;
    if (popped) void'(mq.pop_front());
    if (pushv && !drop) mq.push_back(v);
    @(posedge clk);
    #1;
    sample(m);
    exp_v = {mq.size() != 0, 3'(mq.size()), movf,
             (mq.size() != 0) ? 16'(mq[0]) : 16'h0};
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if2.en = 1; if2.out_ready = 1;
      if2.data_in = (i % 2) ? 16'h7FFF : 16'h8001;
      @(posedge clk);
      #1;
      sample(2);
      nchk++;
      if (obs !== 21'h0) begin
        nfail++;
        $display("FAIL reset_hold cyc%0d got %h want 0", i, obs);
      end
    end
    @(negedge clk);
    idle_all();
    reset = 1'b1;
    step(2, 1, 16'h7FFF, 0, 1);
    step(2, 1, 16'h0000, 0, 1);
    nchk++;
    if (obs !== exp_v || obs[20] !== 1'b1 || obs[15:0] !== 16'h0) begin
      nfail++;
      $display("FAIL impulse_ph0 got %h want %h", obs, exp_v);
    end
    step(2, 1, 16'h0000, 0, 1);
    step(2, 1, 16'h7FFF, 0, 1);
    nchk++;
    if (obs !== exp_v || obs[15:0] !== 16'h7FFF) begin
      nfail++;
      $display("FAIL impulse_ph1 got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_pick();
    int heads[$];
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      if (i <= 6) step(2, 1, 16'(i), 0, 1);
      else        step(2, 0, 16'h0, 0, 1);
      if (obs[20]) heads.push_back(int'(obs[15:0]));
      nchk++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL pick cyc%0d got %h want %h", i, obs, exp_v);
      end
      nchk++;
      if (obs[20] !== (i <= 6 && i % 2 == 0)) begin
        nfail++;
        $display("FAIL pick_valid cyc%0d got %b", i, obs[20]);
      end
    end
    nchk++;
    if (heads.size() != 3 || heads[0] != 2 ||
        heads[1] != 4 || heads[2] != 6) begin
      nfail++;
      $display("FAIL pick_seq got %p want 2,4,6", heads);
    end
  endtask

  task automatic test_avg();
`ifdef FIR_DECIM_AVG_EN
    logic [15:0] a [4];
    logic [15:0] b [4];
    logic [15:0] w [4];
    a = '{16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h8000};
    b = '{16'h7FFF, 16'h0000, 16'hFFFE, 16'h8000};
    w = '{16'h7FFF, 16'h4000, 16'hFFFF, 16'h8000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(2, 1, a[i], 0, 1);
      step(2, 1, b[i], 0, 1);
      nchk++;
      if (obs !== exp_v || obs[15:0] !== w[i] || !obs[20]) begin
        nfail++;
        $display("FAIL avg%0d got %h want %h", i, obs[15:0], w[i]);
      end
    end
`endif
  endtask

  task automatic test_back_pressure();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 16'(10 + i), 0, 0);
      nchk++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL bp_fill cyc%0d got %h want %h", i, obs, exp_v);
      end
      if (i == 3) begin
        nchk++;
        if (obs[19:17] !== 3'd4 || obs[16] !== 1'b0) begin
          nfail++;
          $display("FAIL bp_full got fill %0d ovf %b", obs[19:17], obs[16]);
        end
      end
      if (i == 4) begin
        nchk++;
        if (obs[16] !== 1'b1) begin
          nfail++;
          $display("FAIL bp_ovf got %b want 1", obs[16]);
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      nchk++;
      if (k < 4 && (obs[20] !== 1'b1 || obs[15:0] !== 16'(10 + k))) begin
        nfail++;
        $display("FAIL bp_drain%0d got %h want %0d", k, obs[15:0], 10 + k);
      end else if (k == 4 && obs[20] !== 1'b0) begin
        nfail++;
        $display("FAIL bp_empty got valid %b want 0", obs[20]);
      end
      if (k < 4) step(1, 0, 16'h0, 0, 1);
    end
    nchk++;
    if (obs !== exp_v) begin
      nfail++;
      $display("FAIL bp_end got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 16'(20 + i), 0, 0);
    for (int j = 0; j < 4; j++) begin
      step(1, 1, 16'(24 + j), 0, 1);
      nchk++;
      if (obs !== exp_v || obs[19:17] !== 3'd4 || obs[16] !== 1'b0 ||
          obs[15:0] !== 16'(21 + j)) begin
        nfail++;
        $display("FAIL b2b%0d got %h want %h", j, obs, exp_v);
      end
    end
    for (int j = 0; j < 4; j++) begin
      step(1, 0, 16'h0, 0, 1);
      nchk++;
      if (obs !== exp_v ||
          (j < 3 && obs[15:0] !== 16'(25 + j))) begin
        nfail++;
        $display("FAIL b2b_drain%0d got %h want %h", j, obs, exp_v);
      end
    end
  endtask

  task automatic test_phase_sync();
    do_reset();
    step(4, 1, 16'd10, 0, 1);
    step(4, 1, 16'd11, 0, 1);
    step(4, 1, 16'd12, 1, 1);
    step(4, 1, 16'd13, 0, 1);
    step(4, 1, 16'd14, 0, 1);
    nchk++;
    if (obs !== exp_v || obs[20] !== 1'b0) begin
      nfail++;
      $display("FAIL sync_early got %h want %h", obs, exp_v);
    end
    step(4, 1, 16'd15, 0, 1);
    nchk++;
    if (obs !== exp_v || obs[20] !== 1'b1 || obs[15:0] !== 16'd15) begin
      nfail++;
      $display("FAIL sync_push got %h want valid 15", obs);
    end
    step(4, 0, 16'h0, 0, 1);
    step(4, 1, 16'd30, 0, 1);
    step(4, 1, 16'd31, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(4, 1, 16'(40 + i), 0, 1);
      nchk++;
      if (obs !== exp_v || obs[20] !== (i == 3) ||
          (i == 3 && obs[15:0] !== 16'd43)) begin
        nfail++;
        $display("FAIL sync_rst%0d got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    int ms [3];
    ms = '{1, 2, 4};
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        step(ms[r], $urandom_range(0, 9) < 7, 16'($urandom),
             $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
        nchk++;
        if (obs !== exp_v) begin
          nfail++;
          $display("FAIL rand m%0d cyc%0d got %h want %h",
                   ms[r], c, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    nchk = 0;
    nfail = 0;
    reset = 1'b1;
    idle_all();
    model_clear();
    test_reset();
    test_pick();
    test_avg();
    test_back_pressure();
    test_back_to_back();
    test_phase_sync();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
